// File: rtl/store_controller.sv
// store_controller: writes one finished C tile from the output row buffer to memory, one row per write.
// Outputs are combinational from state and inputs and are forced to zero while reset is asserted.
module store_controller #(
    parameter int ADDR_W = 32,
    parameter int SIZE_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              can_store,
    input  logic [ADDR_W-1:0] tile_C_addr,
    input  logic [ADDR_W-1:0] tile_C_stride,
    input  logic [SIZE_W-1:0] msize,
    input  logic [SIZE_W-1:0] nsize,
    input  logic [ADDR_W-1:0] current_addr,
    input  logic              row_valid,
    output logic              row_buff_read,
    output logic              gen_addr_store,
    output logic [ADDR_W-1:0] next_row_addr_store,
    output logic              interface_en_store,
    output logic              interface_rdwr_store,
    output logic [SIZE_W-1:0] interface_control_store,
    output logic              done_store,
    output logic              store_busy
);
    typedef enum logic {IDLE, WRITE} state_t;

    state_t            state_q, state_d;
    logic [SIZE_W-1:0] msize_q, msize_d;
    logic [SIZE_W-1:0] nsize_q, nsize_d;
    logic [SIZE_W-1:0] row_cnt_q, row_cnt_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic              last;

    // Compare one bit wider so row_cnt + 1 cannot wrap onto msize_q.
    assign last = ((SIZE_W+1)'(row_cnt_q) + (SIZE_W+1)'(1)) == (SIZE_W+1)'(msize_q);

    always_comb begin
        state_d                 = state_q;
        msize_d                 = msize_q;
        nsize_d                 = nsize_q;
        stride_d                = stride_q;
        row_cnt_d               = row_cnt_q;
        row_buff_read           = 1'b0;
        gen_addr_store          = 1'b0;
        next_row_addr_store     = '0;
        interface_en_store      = 1'b0;
        interface_rdwr_store    = 1'b0;
        interface_control_store = '0;
        done_store              = 1'b0;
        store_busy              = 1'b0;
        if (state_q == IDLE) begin
            if (can_store) begin
                gen_addr_store      = 1'b1;
                next_row_addr_store = tile_C_addr;
                msize_d             = msize;
                nsize_d             = nsize;
                stride_d            = tile_C_stride;
                row_cnt_d           = '0;
                state_d             = WRITE;
            end
        end else begin
            store_busy = 1'b1;
            if (msize_q == '0) begin
                done_store = 1'b1;
                state_d    = IDLE;
            end else if (row_valid) begin
                interface_en_store      = 1'b1;
                interface_rdwr_store    = 1'b1;
                interface_control_store = nsize_q;
                row_buff_read           = 1'b1;
                row_cnt_d               = row_cnt_q + SIZE_W'(1);
                if (last) begin
                    done_store = 1'b1;
                    state_d    = IDLE;
                end else begin
                    gen_addr_store      = 1'b1;
                    next_row_addr_store = current_addr + stride_q;
                end
            end
        end
        if (!rst) begin
            row_buff_read           = 1'b0;
            gen_addr_store          = 1'b0;
            next_row_addr_store     = '0;
            interface_en_store      = 1'b0;
            interface_rdwr_store    = 1'b0;
            interface_control_store = '0;
            done_store              = 1'b0;
            store_busy              = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            msize_q   <= '0;
            nsize_q   <= '0;
            stride_q  <= '0;
            row_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            msize_q   <= msize_d;
            nsize_q   <= nsize_d;
            stride_q  <= stride_d;
            row_cnt_q <= row_cnt_d;
        end
    end
endmodule

// File: tb/tb_store_controller.sv
// tb_store_controller: table-driven vectors plus hand-written reset and stall sequences for store_controller.
module tb_store_controller;
    localparam int AW = 32;
    localparam int SW = 5;
    localparam logic [31:0] A  = 32'h0000_1000;
    localparam logic [31:0] S  = 32'h0000_0040;
    localparam logic [31:0] B  = 32'h0000_2000;
    localparam logic [31:0] C  = 32'h0000_3000;
    localparam logic [31:0] W  = 32'hFFFF_FFC0;
    localparam logic [31:0] T  = 32'h0000_0010;

    logic          clk = 1'b0;
    logic          rst;
    logic          can_store;
    logic [AW-1:0] tile_C_addr;
    logic [AW-1:0] tile_C_stride;
    logic [SW-1:0] msize;
    logic [SW-1:0] nsize;
    logic [AW-1:0] current_addr;
    logic          row_valid;
    logic          row_buff_read;
    logic          gen_addr_store;
    logic [AW-1:0] next_row_addr_store;
    logic          interface_en_store;
    logic          interface_rdwr_store;
    logic [SW-1:0] interface_control_store;
    logic          done_store;
    logic          store_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    store_controller #(.ADDR_W(AW), .SIZE_W(SW)) dut (
        .clk(clk),
        .rst(rst),
        .can_store(can_store),
        .tile_C_addr(tile_C_addr),
        .tile_C_stride(tile_C_stride),
        .msize(msize),
        .nsize(nsize),
        .current_addr(current_addr),
        .row_valid(row_valid),
        .row_buff_read(row_buff_read),
        .gen_addr_store(gen_addr_store),
        .next_row_addr_store(next_row_addr_store),
        .interface_en_store(interface_en_store),
        .interface_rdwr_store(interface_rdwr_store),
        .interface_control_store(interface_control_store),
        .done_store(done_store),
        .store_busy(store_busy)
    );

    typedef struct {
        int          r, cs, rv;
        logic [31:0] a, s;
        int          m, n;
        logic [31:0] cur;
        int          gen, en, pop, done, busy;
        logic [31:0] nxt;
        int          ctl;
    } vec_t;

    vec_t v[$];

    // Address and length are only compared where they are meaningful.
    function automatic logic [42:0] pack(input logic g, input logic e, input logic rw, input logic p,
                                         input logic d, input logic b, input logic [31:0] nx,
                                         input logic [4:0] ct);
        return {g, e, rw, p, d, b, g ? nx : 32'h0, e ? ct : 5'h0};
    endfunction

    function automatic logic [42:0] got_pack();
        return pack(gen_addr_store, interface_en_store, interface_rdwr_store, row_buff_read,
                    done_store, store_busy, next_row_addr_store, interface_control_store);
    endfunction

    task automatic check(input string name, input logic [42:0] got, input logic [42:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, exp);
        end
    endtask

    initial begin
        logic [31:0] cur;
        int          pops, done_at, excl_err;
        rst = 1'b0; can_store = 1'b0; row_valid = 1'b0;
        tile_C_addr = '0; tile_C_stride = '0; msize = '0; nsize = '0; current_addr = '0;

        // reset held low, then ten idle cycles
        repeat (2) begin
            @(negedge clk); #1;
            check("reset_outputs", got_pack(), 43'h0);
        end
        @(negedge clk); rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            check($sformatf("idle_%0d", k), got_pack(), 43'h0);
        end

        // r cs rv  a  s  m n  cur       gen en pop done busy nxt ctl
        // 4-row tile, no stalls
        v.push_back('{1,1,1, A,S,4,8, 0,       1,0,0,0,0, A,     0});
        v.push_back('{1,1,1, A,S,4,8, A,       1,1,1,0,1, A+S,   8});
        v.push_back('{1,1,1, A,S,4,8, A+S,     1,1,1,0,1, A+2*S, 8});
        v.push_back('{1,1,1, A,S,4,8, A+2*S,   1,1,1,0,1, A+3*S, 8});
        v.push_back('{1,1,1, A,S,4,8, A+3*S,   0,1,1,1,1, 0,     8});
        v.push_back('{1,0,0, A,S,4,8, 0,       0,0,0,0,0, 0,     0});
        // msize 1, can_store still high after done starts a new tile
        v.push_back('{1,1,1, B,T,1,3, 0,       1,0,0,0,0, B,     0});
        v.push_back('{1,1,1, B,T,1,3, B,       0,1,1,1,1, 0,     3});
        v.push_back('{1,1,1, B,T,1,3, B,       1,0,0,0,0, B,     0});
        v.push_back('{1,1,1, B,T,1,3, B,       0,1,1,1,1, 0,     3});
        v.push_back('{1,0,0, B,T,1,3, 0,       0,0,0,0,0, 0,     0});
        // msize 0: done with no write even though a row is valid
        v.push_back('{1,1,1, C,S,0,4, 0,       1,0,0,0,0, C,     0});
        v.push_back('{1,1,1, C,S,0,4, C,       0,0,0,1,1, 0,     0});
        v.push_back('{1,0,1, C,S,0,4, 0,       0,0,0,0,0, 0,     0});
        // address wrap; can_store dropping mid-tile is ignored
        v.push_back('{1,1,1, W,S,2,4, 0,       1,0,0,0,0, W,     0});
        v.push_back('{1,1,1, W,S,2,4, W,       1,1,1,0,1, 32'h0, 4});
        v.push_back('{1,0,1, W,S,2,4, 32'h0,   0,1,1,1,1, 0,     4});
        v.push_back('{1,0,0, W,S,2,4, 0,       0,0,0,0,0, 0,     0});
        // reset at T+2 abandons the tile; restart begins from row 0
        v.push_back('{1,1,1, A,S,4,8, 0,       1,0,0,0,0, A,     0});
        v.push_back('{1,1,1, A,S,4,8, A,       1,1,1,0,1, A+S,   8});
        v.push_back('{0,1,1, A,S,4,8, A+S,     0,0,0,0,0, 0,     0});
        v.push_back('{1,0,1, A,S,4,8, A+S,     0,0,0,0,0, 0,     0});
        v.push_back('{1,1,1, A,S,4,8, 0,       1,0,0,0,0, A,     0});
        v.push_back('{1,1,1, A,S,4,8, A,       1,1,1,0,1, A+S,   8});
        v.push_back('{1,1,1, A,S,4,8, A+S,     1,1,1,0,1, A+2*S, 8});
        v.push_back('{1,1,1, A,S,4,8, A+2*S,   1,1,1,0,1, A+3*S, 8});
        v.push_back('{1,1,1, A,S,4,8, A+3*S,   0,1,1,1,1, 0,     8});
        v.push_back('{1,0,0, A,S,4,8, 0,       0,0,0,0,0, 0,     0});

        foreach (v[i]) begin
            @(negedge clk);
            rst = v[i].r[0]; can_store = v[i].cs[0]; row_valid = v[i].rv[0];
            tile_C_addr = v[i].a; tile_C_stride = v[i].s;
            msize = SW'(v[i].m); nsize = SW'(v[i].n); current_addr = v[i].cur;
            #1;
            check($sformatf("vec%0d", i), got_pack(),
                  pack(v[i].gen[0], v[i].en[0], v[i].en[0], v[i].pop[0], v[i].done[0],
                       v[i].busy[0], v[i].nxt, SW'(v[i].ctl)));
        end

        // stalled 4-row tile: row_valid low on T+2 and T+3
        tile_C_addr = A; tile_C_stride = S; msize = 5'd4; nsize = 5'd8;
        cur = '0; pops = 0; done_at = -1; excl_err = 0;
        for (int k = 0; k < 20 && done_at < 0; k++) begin
            @(negedge clk);
            can_store = 1'b1;
            row_valid = !(k == 2 || k == 3);
            current_addr = cur;
            #1;
            pops += int'(row_buff_read);
            if (row_buff_read !== interface_en_store || (gen_addr_store && done_store)) excl_err++;
            if ((k == 2 || k == 3) && (row_buff_read || interface_en_store || gen_addr_store || done_store))
                excl_err++;
            if (gen_addr_store) cur = next_row_addr_store;
            if (done_store) done_at = k;
        end
        @(negedge clk); can_store = 1'b0; row_valid = 1'b0;
        check_int("stall_done_cycle", done_at, 6);
        check_int("stall_pops", pops, 4);
        check_int("stall_strobe_rules", excl_err, 0);
        check_int("stall_last_addr", int'(cur), int'(A + 3 * S));
        #1;
        check("after_stall_idle", got_pack(), 43'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
